// File: rtl/div_pkg.sv
// Shared constants and the storage entry layout for the divider result buffer.
package div_pkg;

  localparam int unsigned DIV_M     = 32;
  localparam int unsigned ERR_CNT_W = 8;

  typedef struct packed {
    logic [DIV_M-1:0] quotient;
    logic [DIV_M-1:0] remainder;
    logic             error;
  } div_result_t;

  // Divide-by-zero results carry undefined data; store them as zero.
  function automatic div_result_t make_entry(input logic [DIV_M-1:0] q,
                                             input logic [DIV_M-1:0] r,
                                             input logic             err);
    div_result_t e;
    e.quotient  = err ? '0 : q;
    e.remainder = err ? '0 : r;
    e.error     = err;
    return e;
  endfunction

endpackage

// File: rtl/div_result_mem.sv
// Entry storage for div_result_buffer: one synchronous write port, one asynchronous read port.
module div_result_mem
  import div_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  div_result_t   wr_data,
  input  logic [AW-1:0] rd_addr,
  output div_result_t   rd_data
);

  div_result_t mem [DEPTH];

  // Contents are never reset; validity is tracked by the owner's count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/div_result_buffer.sv
// Ready/valid FIFO holding divider results between the divider and its consumer.
// Define DIV_ERR_COUNT_EN to add the saturating err_count port. M must equal div_pkg::DIV_M.
module div_result_buffer
  import div_pkg::*;
#(
  parameter int unsigned M     = DIV_M,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [M-1:0]               in_quotient,
  input  logic [M-1:0]               in_remainder,
  input  logic                       in_error,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [M-1:0]               out_quotient,
  output logic [M-1:0]               out_remainder,
  output logic                       out_error,
  output logic [$clog2(DEPTH):0]     count
`ifdef DIV_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0]       err_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  div_result_t   wr_data;
  div_result_t   rd_data;

  // Handshake flags come from registered count only; no out_ready -> in_ready path.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_data = make_entry(DIV_M'(in_quotient), DIV_M'(in_remainder), in_error);

  div_result_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Head data is forced to zero whenever the buffer is empty.
  assign out_quotient  = out_valid ? M'(rd_data.quotient)  : '0;
  assign out_remainder = out_valid ? M'(rd_data.remainder) : '0;
  assign out_error     = out_valid ? rd_data.error         : 1'b0;

  // Pointer and occupancy control; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

`ifdef DIV_ERR_COUNT_EN
  // Saturating tally of accepted error results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (flush) begin
      err_count <= '0;
    end else if (push && in_error && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/div_result_buffer.md
DIV_RESULT_BUFFER -- requirements
Module: div_result_buffer

Interface
REQ-001 Parameter M, default 32: operand/result width, matching the divider stage feeding this block.
REQ-002 Parameter DEPTH, default 4: entry count; power of two, >=2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous discard of all stored entries.
REQ-006 in_valid  input  1  upstream result present.
REQ-007 in_ready  output  1  buffer can accept a result this cycle.
REQ-008 in_quotient  input  M  divider quotient.
REQ-009 in_remainder  input  M  divider remainder.
REQ-010 in_error  input  1  divide-by-zero flag from divider.
REQ-011 out_valid  output  1  head entry available.
REQ-012 out_ready  input  1  downstream consumes head entry.
REQ-013 out_quotient  output  M  head quotient.
REQ-014 out_remainder  output  M  head remainder.
REQ-015 out_error  output  1  head error flag.
REQ-016 count  output  $clog2(DEPTH)+1  stored entry count.
REQ-017 err_count  output  8  saturating error tally (present only with DIV_ERR_COUNT_EN).

Function
REQ-018 in_ready SHALL equal (count != DEPTH), derived from registered state only; no combinational path from out_ready.
REQ-019 Push SHALL occur when in_valid && in_ready; the entry is written at the write pointer and count increments.
REQ-020 out_valid SHALL equal (count != 0); out_* SHALL present the entry at the read pointer.
REQ-021 Pop SHALL occur when out_valid && out_ready; read pointer advances and count decrements.
REQ-022 Latency: a result pushed into an empty buffer SHALL appear on out_* with out_valid=1 on the next cycle; no same-cycle pass-through.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and update both pointers.
REQ-024 When full, a simultaneous pop SHALL NOT enable a push in that cycle (in_ready stays 0).
REQ-025 Pointers SHALL wrap modulo DEPTH; full/empty is decided from count, never from pointer equality alone.
REQ-026 A pushed entry with in_error=1 SHALL store quotient and remainder as all-zero, sanitising undefined divider outputs; out_error=1 for that entry.
REQ-027 flush=1 SHALL zero count and both pointers at the next edge, overriding any push or pop in the same cycle.
REQ-028 Pop/push SHALL be ignored when out_ready/in_valid is asserted while the corresponding valid/ready is low; no state change.
REQ-029 out_* data SHALL be all-zero while out_valid=0.

Reset
REQ-030 rst_n low SHALL immediately force count=0, pointers=0, out_valid=0, in_ready=1, out_quotient=0, out_remainder=0, out_error=0, err_count=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; storage array contents need not be cleared.
REQ-032 Reset deassertion SHALL be followed by normal operation on the first subsequent rising edge.

Configuration
REQ-033 Macro DIV_ERR_COUNT_EN defined: err_count port exists; it increments by 1 on each push with in_error=1, saturates at 255, is unaffected by pop, and clears on flush.
REQ-034 Macro DIV_ERR_COUNT_EN undefined: err_count port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-035 Package div_pkg SHALL hold the default width constant (32) and the packed typedef div_result_t {quotient, remainder, error} used for storage entries.
REQ-036 Storage SHALL be a sub-module div_result_mem (DEPTH x div_result_t, one write port, one asynchronous read port); pointer/count control stays in div_result_buffer.

Verification
REQ-037 Reset, push A: q=7 r=3 err=0 -> next cycle out_valid=1, out_quotient=7, out_remainder=3, count=1.
REQ-038 Push 4 entries with out_ready=0 (DEPTH=4) -> count=4, in_ready=0; fifth in_valid ignored; drain yields entries in push order.
REQ-039 Full buffer, in_valid=1 and out_ready=1 same cycle -> one pop only, count=3; next cycle push accepted, count=4.
REQ-040 Push with in_error=1 and q/r driven X -> out_error=1, out_quotient=0, out_remainder=0; with DIV_ERR_COUNT_EN, err_count=1; 300 error pushes/pops -> err_count=255.
REQ-041 Count=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-042 Assert rst_n=0 asynchronously with count=3 -> outputs zero before next clock edge; after release, a push at pointer 0 reads back correctly.
